// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with lane steering, alignment exceptions and a handshake bus
// Optional bus-wait timeout (buserr) is built in when LSU_TIMEOUT_EN is defined.

`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LBU_OP 8'b11100100
`define EXE_LH_OP  8'b11100001
`define EXE_LHU_OP 8'b11100101
`define EXE_LW_OP  8'b11100011
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`endif

module load_store_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata_in,
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_be,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              done,
   output logic [31:0]       result,
   output logic              adel,
   output logic              ades,
   output logic              buserr,
   output logic [ADDR_W-1:0] badvaddr
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("load_store_unit: TIMEOUT must be within 1..65535");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   // sz: 0 byte, 1 half, 2 word
   typedef struct packed {
      logic       ld;
      logic       st;
      logic [1:0] sz;
      logic       sx;
   } dec_t;

   function automatic dec_t decode(input logic [7:0] o);
      dec_t d;
      d = '0;
      case (o)
         `EXE_LB_OP:  begin d.ld = 1'b1; d.sz = 2'd0; d.sx = 1'b1; end
         `EXE_LBU_OP: begin d.ld = 1'b1; d.sz = 2'd0; end
         `EXE_LH_OP:  begin d.ld = 1'b1; d.sz = 2'd1; d.sx = 1'b1; end
         `EXE_LHU_OP: begin d.ld = 1'b1; d.sz = 2'd1; end
         `EXE_LW_OP:  begin d.ld = 1'b1; d.sz = 2'd2; end
         `EXE_SB_OP:  begin d.st = 1'b1; d.sz = 2'd0; end
         `EXE_SH_OP:  begin d.st = 1'b1; d.sz = 2'd1; end
         `EXE_SW_OP:  begin d.st = 1'b1; d.sz = 2'd2; end
         default:     d = '0;
      endcase
      return d;
   endfunction

   state_t              state_q, state_d;
   logic [7:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         result_q, result_d;
   logic                adel_q, adel_d;
   logic                ades_q, ades_d;
   logic [ADDR_W-1:0]   badvaddr_q, badvaddr_d;
`ifdef LSU_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   logic                buserr_q, buserr_d;
   logic [15:0]         cnt_q, cnt_d;
`endif

   dec_t        in_dec, q_dec;
   logic        in_mis;
   logic [1:0]  lane;
   logic [31:0] rd_shift;
   logic [31:0] load_val;
   logic [3:0]  be_val;
   logic [31:0] wd_val;
   logic        in_bus;

   assign in_dec = decode(op);
   assign q_dec  = decode(op_q);
   assign in_mis = ((in_dec.sz == 2'd1) && addr[0]) || ((in_dec.sz == 2'd2) && (addr[1:0] != 2'b00));
   assign lane   = addr_q[1:0];

   // Loads pick the addressed lane out of the full bus word.
   always_comb begin
      rd_shift = bus_rdata >> {lane, 3'b000};
      case (q_dec.sz)
         2'd0:    load_val = {{24{q_dec.sx & rd_shift[7]}}, rd_shift[7:0]};
         2'd1:    load_val = {{16{q_dec.sx & rd_shift[15]}}, rd_shift[15:0]};
         default: load_val = bus_rdata;
      endcase
   end

   always_comb begin
      case (q_dec.sz)
         2'd0: begin
            be_val = 4'b0001 << lane;
            wd_val = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            be_val = 4'b0011 << lane;
            wd_val = {2{wdata_q[15:0]}};
         end
         default: begin
            be_val = 4'b1111;
            wd_val = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      result_d   = result_q;
      adel_d     = adel_q;
      ades_d     = ades_q;
      badvaddr_d = badvaddr_q;
`ifdef LSU_TIMEOUT_EN
      buserr_d   = buserr_q;
      cnt_d      = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = op;
               addr_d  = addr;
               wdata_d = wdata_in;
               // No-ops and misaligned accesses never touch the bus.
               if (!(in_dec.ld || in_dec.st) || in_mis) begin
                  state_d    = S_RESP;
                  result_d   = '0;
                  adel_d     = in_dec.ld & in_mis;
                  ades_d     = in_dec.st & in_mis;
                  badvaddr_d = in_mis ? addr : '0;
`ifdef LSU_TIMEOUT_EN
                  buserr_d   = 1'b0;
`endif
               end else begin
                  state_d = S_BUS;
`ifdef LSU_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         S_BUS: begin
            if (bus_ack) begin
               state_d  = S_RESP;
               result_d = q_dec.ld ? load_val : '0;
               adel_d   = 1'b0;
               ades_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
               buserr_d = 1'b0;
`endif
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               state_d    = S_RESP;
               result_d   = '0;
               adel_d     = 1'b0;
               ades_d     = 1'b0;
               buserr_d   = 1'b1;
               badvaddr_d = addr_q;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         result_q   <= '0;
         adel_q     <= 1'b0;
         ades_q     <= 1'b0;
         badvaddr_q <= '0;
`ifdef LSU_TIMEOUT_EN
         buserr_q   <= 1'b0;
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         result_q   <= result_d;
         adel_q     <= adel_d;
         ades_q     <= ades_d;
         badvaddr_q <= badvaddr_d;
`ifdef LSU_TIMEOUT_EN
         buserr_q   <= buserr_d;
         cnt_q      <= cnt_d;
`endif
      end
   end

   // Bus outputs decode straight from state so reset drops them without waiting for a clock.
   assign in_bus    = (state_q == S_BUS);
   assign in_ready  = resetn & (state_q == S_IDLE);
   assign bus_req   = in_bus;
   assign bus_we    = in_bus & q_dec.st;
   assign bus_be    = in_bus ? be_val : 4'b0000;
   assign bus_addr  = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus_wdata = (in_bus && q_dec.st) ? wd_val : 32'd0;
   assign done      = (state_q == S_RESP);
   assign result    = result_q;
   assign adel      = adel_q;
   assign ades      = ades_q;
   assign badvaddr  = badvaddr_q;
`ifdef LSU_TIMEOUT_EN
   assign buserr    = buserr_q;
`else
   assign buserr    = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a bus responder and reference model

module tb_load_store_unit;
   localparam int T = 4;
`ifdef LSU_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5;
   localparam logic [7:0] LW = 8'hE3, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

   typedef struct {
      logic [31:0] result;
      bit          chk_res;
      logic        adel, ades, buserr;
      logic [31:0] badv;
      int          lat;
      int          acc;
   } resp_t;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr, wdata, rdata;
      int          delay;
      bit          tmo;
   } bus_t;

   logic        clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, bus_ack = 1'b0;
   logic [7:0]  op = 8'h00;
   logic [31:0] addr = '0, wdata_in = '0, bus_rdata = '0;
   logic        in_ready, bus_req, bus_we, done, adel, ades, buserr;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr, bus_wdata, result, badvaddr;

   int n_chk = 0, n_fail = 0, cyc = 0;
   resp_t resp_q[$];
   bus_t  bus_q[$];

   load_store_unit #(.ADDR_W(32), .TIMEOUT(T)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .op(op), .addr(addr),
      .wdata_in(wdata_in), .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .done(done), .result(result),
      .adel(adel), .ades(ades), .buserr(buserr), .badvaddr(badvaddr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic void decode(input logic [7:0] o, output int sz, output bit ld, output bit sx);
      sz = 0; ld = 0; sx = 0;
      case (o)
         LB:  begin sz = 1; ld = 1; sx = 1; end
         LBU: begin sz = 1; ld = 1; end
         LH:  begin sz = 2; ld = 1; sx = 1; end
         LHU: begin sz = 2; ld = 1; end
         LW:  begin sz = 4; ld = 1; end
         SB:  sz = 1;
         SH:  sz = 2;
         SW:  sz = 4;
         default: sz = 0;
      endcase
   endfunction

   // Offer one operation; the model's expectations are queued at the edge it will be accepted on.
   task automatic issue(input logic [7:0] o, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] r, input int d, input bit push_resp);
      int guard = 0, sz, lane;
      bit ld, sx, mis;
      resp_t e;
      bus_t  b;
      logic [31:0] v;
      @(negedge clk);
      in_valid = 1'b1; op = o; addr = a; wdata_in = w;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         chk("accept_wait", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      decode(o, sz, ld, sx);
      lane = int'(a % 4);
      mis  = (sz == 2 && (a % 2) != 0) || (sz == 4 && lane != 0);
      e.acc = cyc + 1; e.result = 0; e.chk_res = 1; e.adel = 0; e.ades = 0; e.buserr = 0; e.badv = 0;
      if (sz == 0) begin
         e.lat = 1;
      end else if (mis) begin
         e.lat = 1; e.adel = ld; e.ades = !ld; e.badv = a;
      end else begin
         b.we    = !ld;
         b.be    = (sz == 1) ? 4'(1 << lane) : (sz == 2) ? 4'(3 << lane) : 4'hF;
         b.addr  = a & ~32'd3;
         b.wdata = ld ? 32'd0 : (sz == 1) ? (w & 32'hFF) * 32'h01010101 :
                   (sz == 2) ? (w & 32'hFFFF) * 32'h00010001 : w;
         b.rdata = r;
         b.delay = d;
         b.tmo   = TMO_EN && d >= T;
         bus_q.push_back(b);
         if (b.tmo) begin
            e.lat = T + 1; e.buserr = 1; e.badv = a;
         end else begin
            e.lat = d + 2;
            e.chk_res = ld;
            if (ld) begin
               if (sz == 4) v = r;
               else begin
                  v = (r >> (8 * lane)) & ((sz == 1) ? 32'hFF : 32'hFFFF);
                  if (sx && sz == 1 && v >= 32'h80) v = v | 32'hFFFFFF00;
                  if (sx && sz == 2 && v >= 32'h8000) v = v | 32'hFFFF0000;
               end
               e.result = v;
            end
         end
      end
      if (push_resp) resp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0; op = 8'($urandom); addr = $urandom; wdata_in = $urandom;
   endtask

   // Bus responder: checks request fields every BUS cycle, acks after the queued delay, and
   // toggles ack randomly while no request is pending.
   bus_t cur;
   bit   active = 0;
   int   wait_left = 0, req_cycles = 0;
   always @(negedge clk) begin
      if (!resetn) begin
         active = 0;
         bus_ack = 1'b0;
      end else if (bus_req) begin
         if (!active) begin
            if (bus_q.size() == 0) chk("bus_unexpected_req", 32'd1, 32'd0);
            else cur = bus_q.pop_front();
            active = 1; wait_left = cur.delay; req_cycles = 0;
         end
         req_cycles++;
         chk("bus_we", 32'(bus_we), 32'(cur.we));
         chk("bus_be", 32'(bus_be), 32'(cur.be));
         chk("bus_addr", bus_addr, cur.addr);
         chk("bus_wdata", bus_wdata, cur.wdata);
         if (wait_left == 0) begin
            bus_ack = 1'b1; bus_rdata = cur.rdata;
         end else begin
            wait_left--;
            bus_ack = 1'b0; bus_rdata = $urandom;
         end
      end else begin
         if (active) begin
            chk("bus_req_cycles", 32'(req_cycles), cur.tmo ? 32'(T) : 32'(cur.delay + 1));
            active = 0;
         end
         bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      end
   end

   // Response monitor: pops on done, otherwise checks that result and flags hold.
   logic [31:0] last_res = 0, last_badv = 0;
   logic        last_adel = 0, last_ades = 0, last_buserr = 0;
   bit          res_valid = 1, badv_valid = 1;
   always @(negedge clk) begin
      resp_t e;
      if (!resetn) begin
         last_res = 0; last_badv = 0; last_adel = 0; last_ades = 0; last_buserr = 0;
         res_valid = 1; badv_valid = 1;
      end else if (done) begin
         if (resp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            e = resp_q.pop_front();
            chk("done_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
            chk("adel", 32'(adel), 32'(e.adel));
            chk("ades", 32'(ades), 32'(e.ades));
            chk("buserr", 32'(buserr), 32'(e.buserr));
            if (e.chk_res) chk("result", result, e.result);
            if (e.adel || e.ades || e.buserr) chk("badvaddr", badvaddr, e.badv);
            last_res = e.result; res_valid = e.chk_res;
            last_adel = e.adel; last_ades = e.ades; last_buserr = e.buserr;
            last_badv = e.badv; badv_valid = e.adel || e.ades || e.buserr;
         end
      end else begin
         chk("hold_adel", 32'(adel), 32'(last_adel));
         chk("hold_ades", 32'(ades), 32'(last_ades));
         chk("hold_buserr", 32'(buserr), 32'(last_buserr));
         if (res_valid) chk("hold_result", result, last_res);
         if (badv_valid) chk("hold_badvaddr", badvaddr, last_badv);
      end
   end

   initial begin
      logic [7:0] codes [8];
      logic [7:0] o;
      logic [31:0] a;
      int sz, guard;
      bit ld, sx;
      codes = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_be", 32'(bus_be), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'd0, adel, ades, buserr}, 32'd0);
      chk("rst_badvaddr", badvaddr, 32'd0);
      #2 resetn = 1'b1;

      issue(LB, 32'h1003, 32'h0, 32'h80FF_0000, 0, 1);
      issue(LHU, 32'h2002, 32'h0, 32'hBEEF_1234, 3, 1);
      issue(SH, 32'h3001, 32'h5555_AAAA, 32'h0, 0, 1);
      issue(SB, 32'h40, 32'h1234_56A5, 32'h0, 1, 1);
      issue(8'h00, 32'h77, 32'h0, 32'h0, 0, 1);
`ifdef LSU_TIMEOUT_EN
      issue(LW, 32'h500, 32'h0, 32'hDEAD_BEEF, 1000, 1);
`endif

      // Asynchronous reset in the middle of a bus access.
      issue(LW, 32'h600, 32'h0, 32'h0, 50, 0);
      chk("rst_mid_pre_req", 32'(bus_req), 32'd1);
      #2 resetn = 1'b0;
      #1 chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_mid_no_done", 32'(done), 32'd0);
      end
      #2 resetn = 1'b1;
      #1 chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
      chk("rst_rel_bus_req", 32'(bus_req), 32'd0);

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            o = 8'($urandom);
            decode(o, sz, ld, sx);
            if (sz != 0) o = 8'h00;
         end else o = codes[$urandom_range(0, 7)];
         decode(o, sz, ld, sx);
         a = $urandom;
         if (sz > 1 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
         issue(o, a, $urandom, $urandom, int'($urandom_range(0, 5)), 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      guard = 0;
      while ((resp_q.size() != 0 || bus_q.size() != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
      chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
